multdiv_sequencer: RTL

//  Sequences the shared multi-cycle mult/div unit from the DX stage. Detects R-type mul/div in DX,

---
 rtl/md_seq_pkg.sv | 23 ++
 rtl/md_cycle_counter.sv | 27 ++
 rtl/multdiv_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/md_seq_pkg.sv
// Shared constants for the mult/div sequencer: R-type decode fields, FSM encoding and
// rstatus exception codes.
package md_seq_pkg;

   localparam logic [4:0] OPC_RTYPE = 5'b00000;
   localparam logic [4:0] ALU_MUL   = 5'b00110;
   localparam logic [4:0] ALU_DIV   = 5'b00111;

   localparam int unsigned RSTATUS_MUL = 4;
   localparam int unsigned RSTATUS_DIV = 5;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StStart = 2'b01,
      StWait  = 2'b10,
      StDone  = 2'b11
   } md_state_e;

   function automatic logic insn_is_md(input logic [4:0] opcode, input logic [4:0] alu_op);
      return (opcode == OPC_RTYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));
   endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// Free-running WAIT-cycle counter with synchronous clear and count enable.
// Clear has priority over enable; wraps silently at 2**CNT_W.
module md_cycle_counter #(
   parameter int unsigned CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences the shared multi-cycle mult/div unit from DX: start pulse, pipeline freeze, result
// handoff to XM. Optional watchdog enabled by defining MULTDIV_SEQ_TIMEOUT_EN.
module multdiv_sequencer
   import md_seq_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 40,
   parameter int unsigned CNT_W       = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       dx_insn,
   input  logic              dx_flush,
   input  logic [DATA_W-1:0] md_result,
   input  logic              md_exception,
   input  logic              md_ready,
   output logic              ctrl_mult,
   output logic              ctrl_div,
   output logic              stall,
   output logic              xm_bubble,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data,
   output logic              res_exception,
   output logic [DATA_W-1:0] res_status,
   output logic              busy
);

   md_state_e         state_q, state_d;
   logic              is_div_q, is_div_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic              res_exc_q, res_exc_d;
   logic [DATA_W-1:0] res_status_q, res_status_d;

   logic              md_op;
   logic              cnt_clear;
   logic              cnt_en;
   logic [CNT_W-1:0]  cycle_cnt;
   logic              wd_hit;
   logic              timeout;
   logic [DATA_W-1:0] exc_code;

   assign md_op = insn_is_md(dx_insn[31:27], dx_insn[6:2]);

   // Operand/rd fields are consumed by the register file and XM, not here.
   logic unused_insn_bits;
   assign unused_insn_bits = ^{dx_insn[26:7], dx_insn[1:0]};

   md_cycle_counter #(
      .CNT_W (CNT_W)
   ) u_cycle_counter (
      .clock  (clock),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .count  (cycle_cnt)
   );

   assign wd_hit = (cycle_cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef MULTDIV_SEQ_TIMEOUT_EN
   assign timeout = wd_hit;
`else
   // Counter kept for debug visibility only; it never forces WAIT to exit.
   logic unused_wd_hit;
   assign unused_wd_hit = wd_hit;
   assign timeout       = 1'b0;
`endif

   assign exc_code = is_div_q ? DATA_W'(RSTATUS_DIV) : DATA_W'(RSTATUS_MUL);

   always_comb begin
      state_d      = state_q;
      is_div_d     = is_div_q;
      res_data_d   = res_data_q;
      res_exc_d    = res_exc_q;
      res_status_d = res_status_q;
      cnt_clear    = 1'b0;
      cnt_en       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (md_op && !dx_flush) begin
               state_d  = StStart;
               is_div_d = (dx_insn[6:2] == ALU_DIV);
            end
         end
         StStart: begin
            cnt_clear = 1'b1;
            state_d   = dx_flush ? StIdle : StWait;
         end
         StWait: begin
            cnt_en = 1'b1;
            // Flush beats a coincident md_ready: the op was squashed.
            if (dx_flush) begin
               state_d = StIdle;
            end else if (md_ready) begin
               state_d      = StDone;
               res_exc_d    = md_exception;
               res_data_d   = md_exception ? '0 : md_result;
               res_status_d = md_exception ? exc_code : '0;
            end else if (timeout) begin
               state_d      = StDone;
               res_exc_d    = 1'b1;
               res_data_d   = '0;
               res_status_d = exc_code;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         is_div_q     <= 1'b0;
         res_data_q   <= '0;
         res_exc_q    <= 1'b0;
         res_status_q <= '0;
      end else begin
         state_q      <= state_d;
         is_div_q     <= is_div_d;
         res_data_q   <= res_data_d;
         res_exc_q    <= res_exc_d;
         res_status_q <= res_status_d;
      end
   end

   assign ctrl_mult     = (state_q == StStart) && !is_div_q;
   assign ctrl_div      = (state_q == StStart) && is_div_q;
   // Asserted in the decode cycle itself; released in DONE so the op advances into XM.
   assign stall         = md_op && (state_q != StDone);
   assign xm_bubble     = stall;
   assign res_valid     = (state_q == StDone);
   assign res_data      = res_data_q;
   assign res_exception = res_exc_q;
   assign res_status    = res_status_q;
   assign busy          = (state_q != StIdle);

endmodule
